// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - writeback queue feeding the regfile write decoder
// Buffers WB requests, drains one write per cycle, filters $0 and forwards pending data.
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clock,
  input  logic                       ctrl_reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_reg,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       stall_wb,
  output logic [ADDR_W-1:0]          out_write_reg,
  output logic                       out_write_enable,
  output logic [DATA_W-1:0]          out_write_data,
  input  logic [ADDR_W-1:0]          rd_reg_a,
  output logic                       fwd_hit_a,
  output logic [DATA_W-1:0]          fwd_data_a,
  input  logic [ADDR_W-1:0]          rd_reg_b,
  output logic                       fwd_hit_b,
  output logic [DATA_W-1:0]          fwd_data_b,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  scan_idx [DEPTH];

  logic push;
  logic pop;

  assign in_ready = (count != CNT_W'(DEPTH));
  // $0 requests complete the handshake but never occupy an entry.
  assign push = in_valid && in_ready && (in_reg != '0);
  assign pop  = (count != '0) && !stall_wb;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      valid            <= '0;
      out_write_enable <= 1'b0;
      out_write_reg    <= '0;
      out_write_data   <= '0;
    end else begin
      out_write_enable <= pop;
      if (pop) begin
        out_write_reg  <= reg_mem[head];
        out_write_data <= data_mem[head];
        valid[head]    <= 1'b0;
        head           <= head + 1'b1;
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      reg_mem[tail]  <= in_reg;
      data_mem[tail] <= in_data;
    end
  end

  // Scan order runs oldest (head) to youngest, so later matches override earlier ones.
  for (genvar g = 0; g < DEPTH; g++) begin : g_scan
    assign scan_idx[g] = head + PTR_W'(g);
  end

  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    if (out_write_enable && (out_write_reg == rd_reg_a)) begin
      fwd_hit_a  = 1'b1;
      fwd_data_a = out_write_data;
    end
    if (out_write_enable && (out_write_reg == rd_reg_b)) begin
      fwd_hit_b  = 1'b1;
      fwd_data_b = out_write_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[scan_idx[i]] && (reg_mem[scan_idx[i]] == rd_reg_a)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = data_mem[scan_idx[i]];
      end
      if (valid[scan_idx[i]] && (reg_mem[scan_idx[i]] == rd_reg_b)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = data_mem[scan_idx[i]];
      end
    end
    if (rd_reg_a == '0) begin
      fwd_hit_a  = 1'b0;
      fwd_data_a = '0;
    end
    if (rd_reg_b == '0) begin
      fwd_hit_b  = 1'b0;
      fwd_data_b = '0;
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - directed self-checking bench for wb_write_queue
// Linear directed steps; inputs change 1 time unit after each rising edge.
module tb_wb_write_queue;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        stall_wb;
  logic [4:0]  out_write_reg;
  logic        out_write_enable;
  logic [31:0] out_write_data;
  logic [4:0]  rd_reg_a;
  logic        fwd_hit_a;
  logic [31:0] fwd_data_a;
  logic [4:0]  rd_reg_b;
  logic        fwd_hit_b;
  logic [31:0] fwd_data_b;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  wb_write_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .stall_wb(stall_wb),
    .out_write_reg(out_write_reg), .out_write_enable(out_write_enable),
    .out_write_data(out_write_data),
    .rd_reg_a(rd_reg_a), .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
    .rd_reg_b(rd_reg_b), .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int strobes;
    int pushed;
    int got;
    int maxc;
    logic acc;

    ctrl_reset_n = 1'b0;
    in_valid = 1'b0; in_reg = '0; in_data = '0; stall_wb = 1'b0;
    rd_reg_a = '0; rd_reg_b = '0;
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_ready", in_ready, 1);
    check("rst_we", out_write_enable, 0);
    check("rst_reg", out_write_reg, 0);
    check("rst_data", out_write_data, 0);
    check("rst_hit_a", fwd_hit_a, 0);
    check("rst_fdata_a", fwd_data_a, 0);
    ctrl_reset_n = 1'b1;
    tick();

    // Single write latency
    rd_reg_a = 5'd5;
    push(5'd5, 32'hDEADBEEF);
    check("single_cnt_k", count, 1);
    check("single_we_k", out_write_enable, 0);
    check("single_fwd_q", fwd_hit_a, 1);
    check("single_fwdd_q", fwd_data_a, 32'hDEADBEEF);
    tick();
    check("single_we_k1", out_write_enable, 1);
    check("single_reg", out_write_reg, 5);
    check("single_data", out_write_data, 32'hDEADBEEF);
    check("single_cnt_k1", count, 0);
    check("single_fwd_out", fwd_data_a, 32'hDEADBEEF);
    tick();
    check("single_we_k2", out_write_enable, 0);
    check("single_reg_hold", out_write_reg, 5);
    check("single_fwd_gone", fwd_hit_a, 0);

    // Mid-operation reset
    stall_wb = 1'b1;
    push(5'd1, 32'h1);
    push(5'd2, 32'h2);
    push(5'd3, 32'h3);
    check("midrst_pre_cnt", count, 3);
    #2 ctrl_reset_n = 1'b0;
    #1;
    check("midrst_cnt", count, 0);
    check("midrst_we", out_write_enable, 0);
    check("midrst_reg", out_write_reg, 0);
    check("midrst_ready", in_ready, 1);
    tick();
    ctrl_reset_n = 1'b1;
    stall_wb = 1'b0;
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_write_enable) strobes++;
    end
    check("midrst_no_strobe", strobes, 0);

    // Full / backpressure
    stall_wb = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h10));
    check("full_cnt", count, 4);
    check("full_ready", in_ready, 0);
    in_valid = 1'b1; in_reg = 5'd5; in_data = 32'h50;
    tick();
    check("full_held_cnt", count, 4);
    stall_wb = 1'b0;
    check("full_pop_ready", in_ready, 0);
    tick();
    check("full_s1_we", out_write_enable, 1);
    check("full_s1_reg", out_write_reg, 1);
    check("full_s1_data", out_write_data, 32'h10);
    check("full_s1_ready", in_ready, 1);
    check("full_s1_cnt", count, 3);
    tick();
    in_valid = 1'b0;
    check("full_s2_reg", out_write_reg, 2);
    check("full_s2_cnt", count, 3);
    tick();
    check("full_s3_we", out_write_enable, 1);
    check("full_s3_reg", out_write_reg, 3);
    tick();
    check("full_s4_we", out_write_enable, 1);
    check("full_s4_reg", out_write_reg, 4);
    check("full_s4_data", out_write_data, 32'h40);
    tick();
    check("full_s5_reg", out_write_reg, 5);
    check("full_s5_data", out_write_data, 32'h50);
    tick();
    check("full_idle_we", out_write_enable, 0);
    check("full_idle_cnt", count, 0);

    // $0 filter
    rd_reg_a = 5'd0;
    in_valid = 1'b1; in_reg = 5'd0; in_data = 32'h1234;
    check("zero_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("zero_cnt", count, 0);
    check("zero_hit_a", fwd_hit_a, 0);
    check("zero_fdata_a", fwd_data_a, 0);
    tick();
    check("zero_no_we", out_write_enable, 0);

    // Forwarding priority
    stall_wb = 1'b1;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    rd_reg_a = 5'd7; rd_reg_b = 5'd9;
    #1;
    check("fwd_hit_a", fwd_hit_a, 1);
    check("fwd_data_a", fwd_data_a, 32'h22);
    check("fwd_hit_b", fwd_hit_b, 0);
    check("fwd_data_b", fwd_data_b, 0);
    rd_reg_b = 5'd7;
    #1;
    check("fwd_b_indep", fwd_data_b, 32'h22);
    stall_wb = 1'b0;
    tick();
    stall_wb = 1'b1;
    check("fwd_p1_reg", out_write_data, 32'h11);
    check("fwd_p1_data", fwd_data_a, 32'h22);
    tick();
    check("fwd_p2_data", fwd_data_a, 32'h22);
    check("fwd_p2_cnt", count, 1);
    stall_wb = 1'b0;
    tick();
    check("fwd_p3_we", out_write_enable, 1);
    check("fwd_p3_data", fwd_data_a, 32'h22);
    tick();
    check("fwd_done_hit", fwd_hit_a, 0);
    rd_reg_a = '0; rd_reg_b = '0;

    // Wrap-around with periodic stall
    pushed = 0; got = 0; maxc = 0;
    for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
      stall_wb = ((cyc / 3) % 2) == 1;
      in_valid = (pushed < 12);
      in_reg   = 5'(pushed + 1);
      in_data  = 32'((pushed + 1) * 'h100);
      acc = in_valid && in_ready;
      tick();
      if (acc) pushed++;
      if (int'(count) > maxc) maxc = int'(count);
      if (out_write_enable) begin
        check("wrap_reg", out_write_reg, 64'(got + 1));
        check("wrap_data", out_write_data, 64'((got + 1) * 'h100));
        got++;
      end
    end
    in_valid = 1'b0;
    check("wrap_total", got, 12);
    check("wrap_pushed", pushed, 12);
    check("wrap_max_le4", (maxc <= 4), 1);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_write_enable) strobes++;
    end
    check("wrap_no_extra", strobes, 0);
    check("wrap_end_cnt", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
